// File: rtl/audio_sample_fifo.sv
// PCM sample FIFO feeding an I2S transmitter; samples are popped on AUD_LRCK edges.
// Optional feature: define AUDIO_VOLUME_EN to add a 3-bit arithmetic-shift volume input.
module audio_sample_fifo #(
  parameter int ADDR_W = 4,
  parameter int STEREO = 0
) (
  input  logic              AUD_XCK,
  input  logic              reset_n,
  input  logic [15:0]       wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              AUD_LRCK,
  output logic [15:0]       audiodata,
  output logic [ADDR_W:0]   fifo_level,
  output logic              underflow,
  input  logic              clr_underflow
`ifdef AUDIO_VOLUME_EN
  ,
  input  logic [2:0]        volume
`endif
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(DEPTH);

  logic signed [15:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic               s1, s2, s3;
  logic               lrck_rise, lrck_fall, pop_due;
  logic               empty, do_wr, do_pop;
  logic signed [15:0] head_sample;
  logic signed [15:0] pop_sample;

`ifdef AUDIO_VOLUME_EN
  function automatic logic signed [15:0] scale_sample(input logic signed [15:0] s,
                                                      input logic [2:0] sh);
    return s >>> sh;
  endfunction
`endif

  assign lrck_rise   = s2 & ~s3;
  assign lrck_fall   = ~s2 & s3;
  assign pop_due     = lrck_rise | ((STEREO != 0) & lrck_fall);
  assign empty       = (fifo_level == '0);
  assign wr_ready    = (fifo_level != FULL);
  assign do_wr       = wr_valid & wr_ready;
  assign do_pop      = pop_due & ~empty;
  assign head_sample = mem[rd_ptr];

`ifdef AUDIO_VOLUME_EN
  assign pop_sample = scale_sample(head_sample, volume);
`else
  assign pop_sample = head_sample;
`endif

  // Sample storage: data only, no reset needed since pointers define validity
  always_ff @(posedge AUD_XCK) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge AUD_XCK) begin
    if (!reset_n) begin
      // Preload the synchronizer with the live LRCK so release sees no edge
      s1         <= AUD_LRCK;
      s2         <= AUD_LRCK;
      s3         <= AUD_LRCK;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      audiodata  <= '0;
      underflow  <= 1'b0;
    end else begin
      s1 <= AUD_LRCK;
      s2 <= s1;
      s3 <= s2;

      if (do_wr)  wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + ADDR_W'(1);

      case ({do_wr, do_pop})
        2'b10:   fifo_level <= fifo_level + (ADDR_W+1)'(1);
        2'b01:   fifo_level <= fifo_level - (ADDR_W+1)'(1);
        default: fifo_level <= fifo_level;
      endcase

      // An empty FIFO at frame time sends silence rather than stale data
      if (pop_due) audiodata <= do_pop ? pop_sample : 16'h0000;

      if (pop_due && empty)  underflow <= 1'b1;
      else if (clr_underflow) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: a vector table plus hand sequences for corner cases.
module tb_audio_sample_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, wr_valid, lrck, clr;
  logic [15:0] wr_data;
  logic        wr_ready, underflow;
  logic [15:0] audiodata;
  logic [4:0]  level;

  logic        st_reset_n, st_wr_valid, st_lrck, st_clr;
  logic [15:0] st_wr_data;
  logic        st_wr_ready, st_underflow;
  logic [15:0] st_audiodata;
  logic [4:0]  st_level;

`ifdef AUDIO_VOLUME_EN
  logic [2:0]  volume;
`endif

  audio_sample_fifo #(.ADDR_W(4), .STEREO(0)) dut (
    .AUD_XCK(clk), .reset_n(reset_n), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .AUD_LRCK(lrck), .audiodata(audiodata), .fifo_level(level),
    .underflow(underflow), .clr_underflow(clr)
`ifdef AUDIO_VOLUME_EN
    , .volume(volume)
`endif
  );

  audio_sample_fifo #(.ADDR_W(4), .STEREO(1)) dut_st (
    .AUD_XCK(clk), .reset_n(st_reset_n), .wr_data(st_wr_data), .wr_valid(st_wr_valid),
    .wr_ready(st_wr_ready), .AUD_LRCK(st_lrck), .audiodata(st_audiodata),
    .fifo_level(st_level), .underflow(st_underflow), .clr_underflow(st_clr)
`ifdef AUDIO_VOLUME_EN
    , .volume(volume)
`endif
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        wv;
    logic [15:0] d;
    logic        lr;
    logic [4:0]  e_lvl;
    logic [15:0] e_ad;
    logic        e_rdy;
    logic        e_uf;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Low phase long enough to settle the synchronizer, then a rise; inputs given
  // here are applied exactly on the cycle the resulting pop happens.
  task automatic frame_rise(input logic wv, input logic [15:0] d, input logic c);
    lrck = 1'b0;
    repeat (3) step();
    lrck = 1'b1;
    step();
    step();
    wr_valid = wv;
    wr_data  = d;
    clr      = c;
    step();
    wr_valid = 1'b0;
    clr      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 16'h1234, 1'b1, 5'd1, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 16'h8000, 1'b0, 5'd2, 16'h0000, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b0, 5'd2, 16'h0000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 5'd2, 16'h0000, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 5'd2, 16'h0000, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 5'd1, 16'h1234, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 16'h7FFF, 1'b0, 5'd2, 16'h1234, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, 5'd2, 16'h1234, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 16'h0042, 1'b1, 5'd3, 16'h1234, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 5'd3, 16'h1234, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 16'h0055, 1'b1, 5'd3, 16'h8000, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 16'h0000, 1'b0, 5'd3, 16'h8000, 1'b1, 1'b0};

    reset_n = 1'b0; wr_valid = 1'b0; wr_data = '0; lrck = 1'b1; clr = 1'b0;
    st_reset_n = 1'b0; st_wr_valid = 1'b0; st_wr_data = '0; st_lrck = 1'b0; st_clr = 1'b0;
`ifdef AUDIO_VOLUME_EN
    volume = 3'd0;
`endif

    // Reset held with LRCK high: no spurious pop on release
    repeat (10) step();
    check("rst_level", level, 5'd0);
    check("rst_audiodata", audiodata, 16'h0000);
    check("rst_underflow", underflow, 1'b0);
    reset_n = 1'b1;
    st_reset_n = 1'b1;
    step();
    check("rst_wr_ready", wr_ready, 1'b1);
    repeat (5) step();
    check("rel_underflow", underflow, 1'b0);
    check("rel_audiodata", audiodata, 16'h0000);
    check("rel_level", level, 5'd0);

    // Table: writes, latency of the pop, falls ignored in mono, write+pop together
    for (int i = 0; i < 12; i++) begin
      wr_valid = tbl[i].wv;
      wr_data  = tbl[i].d;
      lrck     = tbl[i].lr;
      step();
      check($sformatf("vec%0d_level", i), level, tbl[i].e_lvl);
      check($sformatf("vec%0d_audiodata", i), audiodata, tbl[i].e_ad);
      check($sformatf("vec%0d_wr_ready", i), wr_ready, tbl[i].e_rdy);
      check($sformatf("vec%0d_underflow", i), underflow, tbl[i].e_uf);
    end
    wr_valid = 1'b0;

    // Reset mid-stream discards buffered samples
    reset_n = 1'b0;
    lrck = 1'b0;
    step();
    check("midrst_level", level, 5'd0);
    check("midrst_audiodata", audiodata, 16'h0000);
    step();
    reset_n = 1'b1;
    step();

    // Fill to full, hold a 17th write, then one pop frees a slot
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 16'h1000 + 16'(i);
      step();
    end
    check("full_level", level, 5'd16);
    check("full_wr_ready", wr_ready, 1'b0);
    wr_data = 16'hEEEE;
    step();
    step();
    check("full_held_level", level, 5'd16);
    lrck = 1'b1;
    step();
    step();
    step();
    check("full_pop_audiodata", audiodata, 16'h1000);
    check("full_pop_level", level, 5'd15);
    check("full_pop_wr_ready", wr_ready, 1'b1);
    step();
    check("full_refill_level", level, 5'd16);
    check("full_refill_wr_ready", wr_ready, 1'b0);
    wr_valid = 1'b0;

    // Underflow: silence, sticky flag, write on the underflow cycle, clear, set-wins
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    wr_valid = 1'b1;
    wr_data  = 16'h5A5A;
    step();
    wr_valid = 1'b0;
    frame_rise(1'b0, 16'h0000, 1'b0);
    check("uf_pre_audiodata", audiodata, 16'h5A5A);
    check("uf_pre_level", level, 5'd0);
    check("uf_pre_underflow", underflow, 1'b0);
    frame_rise(1'b1, 16'hABCD, 1'b0);
    check("uf_audiodata", audiodata, 16'h0000);
    check("uf_underflow", underflow, 1'b1);
    check("uf_write_level", level, 5'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("uf_clear", underflow, 1'b0);
    frame_rise(1'b0, 16'h0000, 1'b0);
    check("uf_after_audiodata", audiodata, 16'hABCD);
    check("uf_after_level", level, 5'd0);
    frame_rise(1'b0, 16'h0000, 1'b1);
    check("uf_set_wins", underflow, 1'b1);
    check("uf_set_wins_audiodata", audiodata, 16'h0000);

`ifdef AUDIO_VOLUME_EN
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    wr_valid = 1'b1;
    wr_data  = 16'h8000;
    step();
    wr_data  = 16'h0100;
    step();
    wr_valid = 1'b0;
    volume = 3'd3;
    frame_rise(1'b0, 16'h0000, 1'b0);
    check("vol_neg", audiodata, 16'hF000);
    frame_rise(1'b0, 16'h0000, 1'b0);
    check("vol_pos", audiodata, 16'h0020);
    volume = 3'd0;
`endif

    // Stereo: one sample on the rise, the next on the fall
    st_wr_valid = 1'b1;
    st_wr_data  = 16'h1111;
    step();
    st_wr_data  = 16'h2222;
    step();
    st_wr_valid = 1'b0;
    check("st_level_2", st_level, 5'd2);
    st_lrck = 1'b1;
    step();
    step();
    check("st_rise_early", st_audiodata, 16'h0000);
    step();
    check("st_rise_audiodata", st_audiodata, 16'h1111);
    check("st_rise_level", st_level, 5'd1);
    st_lrck = 1'b0;
    repeat (3) step();
    check("st_fall_audiodata", st_audiodata, 16'h2222);
    check("st_fall_level", st_level, 5'd0);
    check("st_underflow", st_underflow, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
